// File: rtl/spi_controller.sv
// SPI mode-0 initiator: serializes one 16-bit register-write frame {write, addr, data}
// MSB first per valid/ready handshake, with setup/hold margins and an optional nCS gap.
module spi_controller #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    output logic       sclk,
    output logic       copi,
    output logic       ncs,
    output logic       busy,
    output logic       done
);

    localparam int MAX_CNT = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CNT_W   = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((CS_GAP > 0) ? CS_GAP - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        HIGH,
        LOW,
        TRAIL,
        GAP
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] div_cnt, div_next;
    logic [3:0]       bit_cnt, bit_next;
    logic [14:0]      shift_reg, shift_next;
    logic             sclk_next, copi_next, ncs_next, done_next;
    logic             div_last;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign div_last  = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            sclk      <= 1'b0;
            copi      <= 1'b0;
            ncs       <= 1'b1;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            div_cnt   <= div_next;
            bit_cnt   <= bit_next;
            shift_reg <= shift_next;
            sclk      <= sclk_next;
            copi      <= copi_next;
            ncs       <= ncs_next;
            done      <= done_next;
        end
    end

    // The R/W bit goes straight onto copi at load; shift_reg keeps the remaining 15 bits.
    always_comb begin
        state_next = state;
        div_next   = div_cnt;
        bit_next   = bit_cnt;
        shift_next = shift_reg;
        sclk_next  = sclk;
        copi_next  = copi;
        ncs_next   = ncs;
        done_next  = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    shift_next = {req_addr, req_data};
                    copi_next  = req_write;
                    ncs_next   = 1'b0;
                    bit_next   = '0;
                    div_next   = '0;
                    state_next = LEAD;
                end
            end
            LEAD, LOW: begin
                if (div_last) begin
                    sclk_next  = 1'b1;
                    div_next   = '0;
                    state_next = HIGH;
                end else begin
                    div_next = div_cnt + 1'b1;
                end
            end
            HIGH: begin
                if (div_last) begin
                    sclk_next = 1'b0;
                    div_next  = '0;
                    if (bit_cnt == 4'd15) begin
                        state_next = TRAIL;
                    end else begin
                        copi_next  = shift_reg[14];
                        shift_next = {shift_reg[13:0], 1'b0};
                        bit_next   = bit_cnt + 4'd1;
                        state_next = LOW;
                    end
                end else begin
                    div_next = div_cnt + 1'b1;
                end
            end
            TRAIL: begin
                if (div_last) begin
                    ncs_next   = 1'b1;
                    copi_next  = 1'b0;
                    done_next  = 1'b1;
                    div_next   = '0;
                    state_next = (CS_GAP > 0) ? GAP : IDLE;
                end else begin
                    div_next = div_cnt + 1'b1;
                end
            end
            GAP: begin
                if (div_cnt == GAP_LAST) begin
                    div_next   = '0;
                    state_next = IDLE;
                end else begin
                    div_next = div_cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                div_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: cycle-level bus model from frame arithmetic, SPI bus
// monitor with a register-block decoder, and directed frame scenarios.
module tb_spi_controller;

    localparam int D       = 4;
    localparam int G       = 4;
    localparam int LOW_LEN = 33 * D;
    localparam int END_T   = LOW_LEN + G;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_write = 1'b0;
    logic [6:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic       req_ready, sclk, copi, ncs, busy, done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spi_controller #(.CLK_DIV(D), .CS_GAP(G)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_data(req_data),
        .sclk(sclk),
        .copi(copi),
        .ncs(ncs),
        .busy(busy),
        .done(done)
    );

    // Model: t counts clk cycles since the last accepted request.
    int          t = 0;
    bit          started = 1'b0;
    logic [15:0] exp_word = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started = 1'b0;
            t = 0;
        end else if ((!started || t >= END_T) && req_valid) begin
            started = 1'b1;
            t = 0;
            exp_word = {req_write, req_addr, req_data};
        end else if (started && t < 1000000) begin
            t++;
        end
    end

    // Vector order: {ncs, sclk, copi, busy, req_ready, done}
    always @(negedge clk) begin : compare
        logic [5:0] act, want;
        int h, b;
        bit bz;
        act = {ncs, sclk, copi, busy, req_ready, done};
        if (!started || t >= LOW_LEN) begin
            bz = started && (t < END_T);
            want = {1'b1, 1'b0, 1'b0, bz, !bz, started && (t == LOW_LEN)};
        end else begin
            h = t / D;
            b = (h >= 32) ? 0 : 15 - h / 2;
            want = {1'b0, (h % 2) == 1, exp_word[b], 1'b1, 1'b0, 1'b0};
        end
        checks++;
        if (act !== want) begin
            errors++;
            $display("[TB] FAIL bus_state t=%0d actual=%b required=%b", t, act, want);
        end
    end

    // Bus monitor and peripheral register decoder.
    logic        prev_sclk = 1'b0, prev_ncs = 1'b1;
    logic [15:0] rx_word = '0;
    int rx_cnt = 0, low_cnt = 0, high_cnt = 0, frames = 0, done_cnt = 0, ready_in_frame = 0;
    int last_word = 0, last_cnt = 0, last_low = 0, last_gap = 0;
    logic [7:0] periph [128];
    logic [7:0] snap [128];

    initial for (int i = 0; i < 128; i++) periph[i] = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) begin
            rx_cnt = 0;
            rx_word = '0;
            low_cnt = 0;
            high_cnt = 0;
        end else begin
            if (done) done_cnt++;
            if (!ncs) begin
                if (prev_ncs) last_gap = high_cnt;
                low_cnt++;
                if (req_ready) ready_in_frame++;
                if (sclk && !prev_sclk) begin
                    rx_word = {rx_word[14:0], copi};
                    rx_cnt++;
                end
            end else begin
                if (!prev_ncs) begin
                    last_word = int'(rx_word);
                    last_cnt = rx_cnt;
                    last_low = low_cnt;
                    frames++;
                    if (rx_cnt == 16 && rx_word[15]) periph[rx_word[14:8]] = rx_word[7:0];
                    rx_cnt = 0;
                    rx_word = '0;
                    low_cnt = 0;
                    high_cnt = 0;
                end
                high_cnt++;
            end
        end
        prev_sclk = sclk;
        prev_ncs = ncs;
    end

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
        end
    endtask

    task automatic applyStimulus(input logic w, input logic [6:0] a, input logic [7:0] d,
                                 input bit hold);
        bit accepted;
        accepted = 1'b0;
        @(posedge clk);
        #1;
        req_write = w;
        req_addr = a;
        req_data = d;
        req_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (req_ready) begin
                @(posedge clk);
                #1;
                accepted = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!hold) req_valid = 1'b0;
        checkOutput("handshake_accepted", int'(accepted), 1);
    endtask

    task automatic waitFrame(input int prev_frames);
        for (int i = 0; i < 600 && frames == prev_frames; i++) @(negedge clk);
        checkOutput("frame_completed", frames, prev_frames + 1);
    endtask

    int f, dc, diffs;

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ncs", int'(ncs), 1);
        checkOutput("reset_sclk", int'(sclk), 0);
        checkOutput("reset_copi", int'(copi), 0);
        checkOutput("reset_ready", int'(req_ready), 1);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;

        f = frames;
        dc = done_cnt;
        applyStimulus(1'b1, 7'h00, 8'hA5, 1'b0);
        waitFrame(f);
        checkOutput("single_word", last_word, 16'h80A5);
        checkOutput("single_edges", last_cnt, 16);
        checkOutput("single_ncs_low", last_low, 132);
        repeat (10) @(negedge clk);
        checkOutput("single_done_pulses", done_cnt - dc, 1);

        f = frames;
        dc = done_cnt;
        applyStimulus(1'b1, 7'h01, 8'hFF, 1'b1);
        req_addr = 7'h02;
        req_data = 8'h00;
        waitFrame(f);
        checkOutput("b2b_first_word", last_word, 16'h81FF);
        checkOutput("b2b_first_ncs_low", last_low, 132);
        applyStimulus(1'b1, 7'h02, 8'h00, 1'b0);
        waitFrame(f + 1);
        checkOutput("b2b_second_word", last_word, 16'h8200);
        checkOutput("b2b_gap", last_gap, G + 1);
        checkOutput("b2b_done_pulses", done_cnt - dc, 2);
        checkOutput("ready_during_frames", ready_in_frame, 0);

        f = frames;
        applyStimulus(1'b1, 7'h7F, 8'h5A, 1'b0);
        for (int i = 0; i < 140; i++) begin
            @(posedge clk);
            #1;
            req_addr = 7'($urandom);
            req_data = 8'($urandom);
            req_write = 1'($urandom);
            req_valid = (i >= 20 && i < 30);
        end
        waitFrame(f);
        checkOutput("stable_word", last_word, 16'hFF5A);
        checkOutput("stable_edges", last_cnt, 16);
        checkOutput("stable_no_extra_frame", int'(busy), 0);

        f = frames;
        dc = done_cnt;
        applyStimulus(1'b1, 7'h01, 8'h33, 1'b0);
        for (int i = 0; i < 400 && rx_cnt < 7; i++) @(negedge clk);
        checkOutput("midreset_edges_seen", rx_cnt, 7);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_ncs", int'(ncs), 1);
        checkOutput("midreset_sclk", int'(sclk), 0);
        checkOutput("midreset_copi", int'(copi), 0);
        checkOutput("midreset_busy", int'(busy), 0);
        checkOutput("midreset_done", int'(done), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("midreset_no_frame", frames, f);
        checkOutput("midreset_no_done", done_cnt, dc);

        f = frames;
        applyStimulus(1'b1, 7'h04, 8'h3C, 1'b0);
        waitFrame(f);
        checkOutput("post_reset_word", last_word, 16'h843C);
        checkOutput("post_reset_ncs_low", last_low, 132);

        f = frames;
        applyStimulus(1'b1, 7'h02, 8'h80, 1'b0);
        waitFrame(f);
        checkOutput("loop_reg02", int'(periph[2]), 8'h80);
        checkOutput("loop_reg01", int'(periph[1]), 8'hFF);
        snap = periph;
        f = frames;
        applyStimulus(1'b0, 7'h02, 8'h11, 1'b0);
        waitFrame(f);
        checkOutput("read_frame_word", last_word, 16'h0211);
        diffs = 0;
        for (int i = 0; i < 128; i++) if (periph[i] !== snap[i]) diffs++;
        checkOutput("read_regs_unchanged", diffs, 0);
        checkOutput("read_reg02_kept", int'(periph[2]), 8'h80);

        repeat (10) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
